// File: rtl/clockdiv_prog_if.sv
// Bus between a programmable tick divider and its user: enable, divisor load
// strobe/value, and the tick, square wave and divisor status coming back.
interface clockdiv_prog_if #(
    parameter int WIDTH = 20
) ();
    logic             en;
    logic [WIDTH-1:0] div_in;
    logic             div_wr;
    logic             div_busy;
    logic [WIDTH-1:0] cur_div;
    logic             tick;
    logic             sq_out;

    modport master (
        output en, div_in, div_wr,
        input  div_busy, cur_div, tick, sq_out
    );

    modport slave (
        input  en, div_in, div_wr,
        output div_busy, cur_div, tick, sq_out
    );
endinterface

// File: rtl/clockdiv_prog.sv
// Runtime-programmable tick / square-wave divider; new divisors take effect at a wrap.
// Optional synchronous phase restart input enabled by defining CLKDIV_PROG_RESTART_EN.
module clockdiv_prog #(
    parameter int WIDTH   = 20,
    parameter int DIV_RST = 1000000
) (
    input  logic                 clk,
    input  logic                 rst,
`ifdef CLKDIV_PROG_RESTART_EN
    input  logic                 restart,
`endif
    clockdiv_prog_if.slave       bus
);
    localparam logic [WIDTH-1:0] DIV_RST_W = WIDTH'(DIV_RST);
    localparam logic [WIDTH-1:0] ONE_W     = WIDTH'(1);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] cur_div_q, cur_div_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic             busy_q, busy_d;
    logic             tick_q, tick_d;
    logic             sq_q, sq_d;
    logic             wrap;
    logic [WIDTH-1:0] wr_val;

    always_comb begin
        cnt_d     = cnt_q;
        cur_div_d = cur_div_q;
        pend_d    = pend_q;
        busy_d    = busy_q;
        sq_d      = sq_q;

        wrap   = bus.en && (cnt_q == (cur_div_q - ONE_W));
        wr_val = (bus.div_in == '0) ? ONE_W : bus.div_in;
        tick_d = wrap;

        if (wrap) begin
            cnt_d = '0;
            sq_d  = ~sq_q;
            // Swap divisors only here so the running period is never cut short or stretched.
            if (busy_q) begin
                cur_div_d = pend_q;
                busy_d    = 1'b0;
            end
        end else if (bus.en) begin
            cnt_d = cnt_q + ONE_W;
        end

`ifdef CLKDIV_PROG_RESTART_EN
        if (restart) begin
            cnt_d     = '0;
            tick_d    = 1'b0;
            sq_d      = 1'b0;
            // pend_q equals cur_div_q whenever nothing is pending, so this is always safe.
            cur_div_d = pend_q;
            busy_d    = 1'b0;
        end
`endif

        // A write in the same cycle lands after any wrap/restart has consumed the old value.
        if (bus.div_wr) begin
            pend_d = wr_val;
            busy_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            cur_div_q <= DIV_RST_W;
            pend_q    <= DIV_RST_W;
            busy_q    <= 1'b0;
            tick_q    <= 1'b0;
            sq_q      <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            cur_div_q <= cur_div_d;
            pend_q    <= pend_d;
            busy_q    <= busy_d;
            tick_q    <= tick_d;
            sq_q      <= sq_d;
        end
    end

    assign bus.div_busy = busy_q;
    assign bus.cur_div  = cur_div_q;
    assign bus.tick     = tick_q;
    assign bus.sq_out   = sq_q;
endmodule

// File: tb/tb_clockdiv_prog.sv
// Self-checking bench for clockdiv_prog: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a period-counting model.
module tb_clockdiv_prog;
    localparam int WIDTH   = 8;
    localparam int DIV_RST = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
`ifdef CLKDIV_PROG_RESTART_EN
    logic restart = 1'b0;
`endif

    clockdiv_prog_if #(.WIDTH(WIDTH)) bus ();

    clockdiv_prog #(.WIDTH(WIDTH), .DIV_RST(DIV_RST)) dut (
        .clk     (clk),
        .rst     (rst),
`ifdef CLKDIV_PROG_RESTART_EN
        .restart (restart),
`endif
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_on   = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Behavioural model: count enabled cycles into the current period; a period
    // ends when that count reaches the divisor in force. sq_out is tick-count parity.
    int m_elapsed = 0;
    int m_period  = DIV_RST;
    int m_pend    = DIV_RST;
    bit m_pvalid  = 1'b0;
    bit m_tick    = 1'b0;
    int m_ticks   = 0;

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_elapsed = 0; m_period = DIV_RST; m_pend = DIV_RST;
                m_pvalid = 1'b0; m_tick = 1'b0; m_ticks = 0;
            end else begin
                bit rs;
                rs = 1'b0;
`ifdef CLKDIV_PROG_RESTART_EN
                rs = restart;
`endif
                if (rs) begin
                    m_elapsed = 0; m_tick = 1'b0; m_ticks = 0;
                    if (m_pvalid) m_period = m_pend;
                    m_pvalid = 1'b0;
                end else if (bus.en) begin
                    m_elapsed++;
                    if (m_elapsed == m_period) begin
                        m_tick = 1'b1; m_ticks++; m_elapsed = 0;
                        if (m_pvalid) begin m_period = m_pend; m_pvalid = 1'b0; end
                    end else begin
                        m_tick = 1'b0;
                    end
                end else begin
                    m_tick = 1'b0;
                end
                if (bus.div_wr) begin
                    m_pend   = (bus.div_in == 0) ? 1 : int'(bus.div_in);
                    m_pvalid = 1'b1;
                end
            end
        end
    end

    // Per-cycle compare of all outputs against the model.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (chk_on) begin
                chk("cyc_tick",    int'(bus.tick),     int'(m_tick));
                chk("cyc_sq_out",  int'(bus.sq_out),   m_ticks % 2);
                chk("cyc_busy",    int'(bus.div_busy), int'(m_pvalid));
                chk("cyc_cur_div", int'(bus.cur_div),  m_period);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_tick(input string name, input int maxc, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.tick && n < maxc);
        if (!bus.tick) chk({name, "_timeout"}, 0, 1);
    endtask

    task automatic write_div(input int v);
        bus.div_in = WIDTH'(v);
        bus.div_wr = 1'b1;
        @(negedge clk);
        bus.div_wr = 1'b0;
    endtask

    initial begin
        int n;
        int mask;
        int ones;
        int toggles;
        logic sq_h;
        logic sq_prev;

        bus.en = 1'b0; bus.div_in = '0; bus.div_wr = 1'b0;
        step(3);
        chk("rst_cur_div", int'(bus.cur_div), DIV_RST);
        chk("rst_tick", int'(bus.tick), 0);
        chk("rst_sq", int'(bus.sq_out), 0);
        chk("rst_busy", int'(bus.div_busy), 0);
        rst = 1'b0;
        bus.en = 1'b1;
        chk_on = 1'b1;

        // Ticks on edges 5, 10, 15 after reset release.
        mask = 0;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            if (bus.tick) mask |= (1 << k);
        end
        chk("t1_tick_edges", mask, 32'h8420);
        chk("t1_sq", int'(bus.sq_out), 1);
        chk("t1_cur_div", int'(bus.cur_div), 5);
        $display("test1 first ticks mask=%h", mask);

        // Load 3 at cnt=1: current period stays 5, then period 3.
        step(1);
        write_div(3);
        chk("t2_busy_set", int'(bus.div_busy), 1);
        wait_tick("t2_a", 20, n);
        chk("t2_old_period_rest", n, 3);
        chk("t2_busy_clr", int'(bus.div_busy), 0);
        chk("t2_cur_div", int'(bus.cur_div), 3);
        wait_tick("t2_b", 20, n);
        chk("t2_new_period", n, 3);
        $display("test2 divisor 5->3 applied at wrap");

        // Enable gap at cnt=2 with divisor 4.
        write_div(4);
        wait_tick("t3_a", 20, n);
        wait_tick("t3_b", 20, n);
        chk("t3_period4", n, 4);
        step(2);
        bus.en = 1'b0;
        sq_h = bus.sq_out;
        step(7);
        chk("t3_no_tick", int'(bus.tick), 0);
        chk("t3_sq_held", int'(bus.sq_out), int'(sq_h));
        bus.en = 1'b1;
        wait_tick("t3_c", 20, n);
        chk("t3_resume", n, 2);
        $display("test3 enable gap resumed after %0d cycles", n);

        // div_in=0 coerces to 1: tick continuous, sq toggles every cycle.
        write_div(0);
        wait_tick("t4_a", 20, n);
        chk("t4_cur_div", int'(bus.cur_div), 1);
        ones = 0; toggles = 0; sq_prev = bus.sq_out;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            ones += int'(bus.tick);
            if (bus.sq_out != sq_prev) toggles++;
            sq_prev = bus.sq_out;
        end
        chk("t4_tick_high", ones, 6);
        chk("t4_sq_toggles", toggles, 6);
        $display("test4 divisor 0 -> 1");

        // Two writes in one period: only the last is applied.
        write_div(6);
        wait_tick("t5_a", 20, n);
        wait_tick("t5_b", 20, n);
        chk("t5_period6", n, 6);
        write_div(7);
        write_div(9);
        wait_tick("t5_c", 20, n);
        chk("t5_old_rest", n, 4);
        chk("t5_last_wins", int'(bus.cur_div), 9);
        chk("t5_busy_clr", int'(bus.div_busy), 0);
        wait_tick("t5_d", 20, n);
        chk("t5_period9", n, 9);
        write_div(8);
        step(2);
        rst = 1'b1;
        @(negedge clk);
        chk("t5_rst_cur_div", int'(bus.cur_div), DIV_RST);
        chk("t5_rst_busy", int'(bus.div_busy), 0);
        chk("t5_rst_sq", int'(bus.sq_out), 0);
        rst = 1'b0;
        $display("test5 last write wins; reset discards pending");

`ifdef CLKDIV_PROG_RESTART_EN
        write_div(6);
        step(2);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        chk("t6_cur_div", int'(bus.cur_div), 6);
        chk("t6_busy", int'(bus.div_busy), 0);
        chk("t6_sq", int'(bus.sq_out), 0);
        wait_tick("t6_a", 20, n);
        chk("t6_period", n, 6);
        $display("test6 restart applied pending 6");
`endif

        // Randomized traffic checked by the per-cycle compare.
        for (int k = 0; k < 4000; k++) begin
            bus.en     = ($urandom_range(0, 7) != 0);
            bus.div_wr = ($urandom_range(0, 7) == 0);
            bus.div_in = WIDTH'($urandom_range(0, 12));
`ifdef CLKDIV_PROG_RESTART_EN
            restart = ($urandom_range(0, 39) == 0);
`endif
            rst = ($urandom_range(0, 499) == 0);
            if (bus.div_wr) $display("rand cyc %0d write div_in=%0d", k, bus.div_in);
            @(negedge clk);
        end
        rst = 1'b0; bus.div_wr = 1'b0;
`ifdef CLKDIV_PROG_RESTART_EN
        restart = 1'b0;
`endif
        step(2);
        chk_on = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
